// File: rtl/gate_test_pkg.sv
// Shared definitions for the gate exerciser: op-code encoding for the
// two-input gate functions, FSM state encoding and the truth-table size.
package gate_test_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOTA = 3'd6;
  localparam logic [2:0] OP_BUF  = 3'd7;

  localparam int NUM_VEC = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/gate_expect.sv
// Combinational reference model of the lab's two-input gates.
// Ports:
//   op  - function select (gate_test_pkg OP_* codes)
//   a,b - gate inputs
//   exp - expected gate output
module gate_expect
  import gate_test_pkg::*;
(
  input  logic [2:0] op,
  input  logic       a,
  input  logic       b,
  output logic       exp
);

  always_comb begin
    exp = 1'b0;
    case (op)
      OP_AND:  exp = a & b;
      OP_OR:   exp = a | b;
      OP_NAND: exp = ~(a & b);
      OP_NOR:  exp = ~(a | b);
      OP_XOR:  exp = a ^ b;
      OP_XNOR: exp = ~(a ^ b);
      OP_NOTA: exp = ~a;
      OP_BUF:  exp = a;
      default: exp = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_tester.sv
// On-board exerciser for a two-input gate. Sweeps {A,B} through 00,01,10,11,
// holding each vector HOLD_CYCLES clocks, samples the synchronised gate output
// on the last cycle of each hold and compares it against the selected function.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   start      - level request; acted on only in IDLE or DONE
//   op_sel     - expected function, captured when a sweep starts
//   y_in       - gate-under-test output (asynchronous, synchronised here)
//   a_out/b_out- registered stimulus
//   busy/done  - sweep in progress / sweep finished (held until next start)
//   pass       - err_cnt==0, valid while done
//   err_cnt    - mismatching vector count (0..4)
//   fail_vec   - bit {A,B} set when that vector mismatched
//   state_dbg  - current FSM state for debug visibility
// Handshake: start is a plain level, no ready; it is simply ignored while busy.
module gate_tester
  import gate_test_pkg::*;
#(
  parameter int HOLD_CYCLES = 10,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] op_sel,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [3:0] fail_vec,
  output logic [1:0] state_dbg
);

  state_e           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [2:0]       op_q, op_d;
  logic [2:0]       err_q, err_d;
  logic [3:0]       fail_q, fail_d;
  logic             a_q, a_d, b_q, b_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic             sync1_q, y_s;
  logic             exp_y;

  gate_expect u_expect (
    .op  (op_q),
    .a   (vec_q[1]),
    .b   (vec_q[0]),
    .exp (exp_y)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    op_d    = op_q;
    err_d   = err_q;
    fail_d  = fail_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // Restart from DONE clears the previous results on the entry edge.
        if (start) begin
          state_d = ST_DRIVE;
          vec_d   = 2'd0;
          hold_d  = '0;
          op_d    = op_sel;
          err_d   = 3'd0;
          fail_d  = 4'd0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      ST_DRIVE: begin
        hold_d = hold_q + 1'b1;
        // HOLD_CYCLES-1 DRIVE cycles plus the SAMPLE cycle make one full hold.
        if (hold_q == CNT_W'(HOLD_CYCLES - 2)) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (y_s != exp_y) begin
          err_d          = err_q + 3'd1;
          fail_d[vec_q]  = 1'b1;
        end
        if (vec_q == 2'(NUM_VEC - 1)) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == 3'd0);
          a_d     = 1'b0;
          b_d     = 1'b0;
        end else begin
          state_d = ST_DRIVE;
          vec_d   = vec_q + 2'd1;
          hold_d  = '0;
          a_d     = vec_d[1];
          b_d     = vec_d[0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= 2'd0;
      hold_q  <= '0;
      op_q    <= 3'd0;
      err_q   <= 3'd0;
      fail_q  <= 4'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      sync1_q <= 1'b0;
      y_s     <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      op_q    <= op_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      sync1_q <= y_in;
      y_s     <= sync1_q;
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_cnt   = err_q;
  assign fail_vec  = fail_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_gate_tester.sv
`timescale 1ns/1ps
module tb_gate_tester;

  localparam int HOLD = 10;

  // Gate models the bench can wire to y_in.
  localparam int G_AND = 0, G_OR = 1, G_ONE = 2, G_XOR = 3;

  logic       clk, rst_n, start, y_in;
  logic [2:0] op_sel;
  logic       a_out, b_out, busy, done, pass;
  logic [2:0] err_cnt;
  logic [3:0] fail_vec;
  logic [1:0] state_dbg;
  int         gate_mode;
  int         n_cmp, n_bad;

  gate_tester #(.HOLD_CYCLES(HOLD), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sel(op_sel), .y_in(y_in),
    .a_out(a_out), .b_out(b_out), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_vec(fail_vec), .state_dbg(state_dbg)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (gate_mode)
      G_AND:   y_in = a_out & b_out;
      G_OR:    y_in = a_out | b_out;
      G_ONE:   y_in = 1'b1;
      default: y_in = a_out ^ b_out;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_outs"}, {a_out, b_out, busy, done, pass, err_cnt, fail_vec},
             32'd0);
  endtask

  // Drive start on a negedge; after the sampling edge busy must be up with
  // cleared results. Returns at the negedge following that edge (cycle 0).
  task automatic start_sweep(input logic [2:0] op, input bit hold);
    @(negedge clk);
    op_sel = op;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("start_busy", busy, 1);
    check_eq("start_clear", {done, err_cnt, fail_vec}, 0);
    check_eq("start_ab", {a_out, b_out}, 0);
    if (!hold) start = 1'b0;
  endtask

  // Follows a sweep from cycle 0 until done or an optional abort cycle.
  // toggle_at>0 changes op_sel to new_op at that cycle.
  task automatic track_sweep(input int stop_at, input int toggle_at,
                             input logic [2:0] new_op, output int cyc);
    int c;
    c = 0;
    while (!done && c < 60 && (stop_at == 0 || c < stop_at)) begin
      if (c % HOLD == 0 || c % HOLD == HOLD - 1) begin
        check_eq($sformatf("vec_c%0d", c), {a_out, b_out}, 32'(c / HOLD));
        check_eq($sformatf("busy_c%0d", c), busy, 1);
      end
      if (toggle_at != 0 && c == toggle_at) op_sel = new_op;
      @(posedge clk);
      @(negedge clk);
      c++;
    end
    cyc = c;
  endtask

  task automatic check_done(input string tag, input int cyc, input logic [2:0] e_err,
                            input logic [3:0] e_fail);
    check_eq({tag, "_lat"}, cyc, 4 * HOLD);
    check_eq({tag, "_done"}, done, 1);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_ab"}, {a_out, b_out}, 0);
    check_eq({tag, "_err"}, err_cnt, e_err);
    check_eq({tag, "_fail"}, fail_vec, e_fail);
    check_eq({tag, "_pass"}, pass, (e_err == 0));
  endtask

  initial begin
    int cyc;
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; start = 1'b0; op_sel = 3'd0; gate_mode = G_AND;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    check_eq("reset_state", state_dbg, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("idle");

    // Correct AND gate, expect AND.
    gate_mode = G_AND;
    start_sweep(3'd0, 1'b0);
    track_sweep(0, 0, 3'd0, cyc);
    check_done("and", cyc, 3'd0, 4'b0000);
    repeat (3) @(negedge clk);
    check_eq("and_done_held", {done, pass}, 2'b11);

    // OR-wired gate, expect AND: vectors 01 and 10 fail.
    gate_mode = G_OR;
    start_sweep(3'd0, 1'b0);
    track_sweep(0, 0, 3'd0, cyc);
    check_done("or_as_and", cyc, 3'd2, 4'b0110);

    // Stuck-at-1, expect NAND: only 11 fails.
    gate_mode = G_ONE;
    start_sweep(3'd2, 1'b0);
    track_sweep(0, 0, 3'd0, cyc);
    check_done("stuck_nand", cyc, 3'd1, 4'b1000);

    // AND gate, expect NOT A: 00, 01, 11 fail.
    gate_mode = G_AND;
    start_sweep(3'd6, 1'b0);
    track_sweep(0, 0, 3'd0, cyc);
    check_done("and_as_nota", cyc, 3'd3, 4'b1011);

    // XOR gate, expect XNOR: all fail.
    gate_mode = G_XOR;
    start_sweep(3'd5, 1'b0);
    track_sweep(0, 0, 3'd0, cyc);
    check_done("xor_as_xnor", cyc, 3'd4, 4'b1111);

    // Reset at cycle 17 of a sweep: everything clears asynchronously.
    gate_mode = G_AND;
    start_sweep(3'd0, 1'b0);
    track_sweep(17, 0, 3'd0, cyc);
    check_eq("abort_cyc", cyc, 17);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    check_eq("midreset_state", state_dbg, 0);
    @(negedge clk);
    rst_n = 1'b1;
    start_sweep(3'd0, 1'b0);
    track_sweep(0, 0, 3'd0, cyc);
    check_done("after_reset", cyc, 3'd0, 4'b0000);

    // start held high, OR gate, captured AND; op_sel flips to OR mid-sweep.
    gate_mode = G_OR;
    start_sweep(3'd0, 1'b1);
    track_sweep(0, 15, 3'd1, cyc);
    check_done("held", cyc, 3'd2, 4'b0110);
    @(posedge clk);
    @(negedge clk);
    check_eq("held_restart_busy", {busy, done}, 2'b10);
    check_eq("held_restart_clear", {err_cnt, fail_vec}, 0);
    start = 1'b0;
    track_sweep(0, 0, 3'd0, cyc);
    check_done("held_second", cyc, 3'd0, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
